// File: rtl/xaddrgen_2d.sv
// Two-level nested-loop address generator: inner duty/period loop, middle
// loop of iterations_i periods, outer loop of iterations2_i blocks. Drives a
// registered address/enable pair with ready backpressure and a last marker.
module xaddrgen_2d #(
  parameter int MEM_ADDR_W = 10,
  parameter int PERIOD_W   = 10,
  parameter int ITER_W     = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         init_i,
  input  logic                         run_i,
  input  logic                         ready_i,
  input  logic        [ITER_W-1:0]     iterations_i,
  input  logic        [ITER_W-1:0]     iterations2_i,
  input  logic        [PERIOD_W-1:0]   period_i,
  input  logic        [PERIOD_W-1:0]   duty_i,
  input  logic        [PERIOD_W-1:0]   delay_i,
  input  logic        [MEM_ADDR_W-1:0] start_i,
  input  logic signed [MEM_ADDR_W-1:0] incr_i,
  input  logic signed [MEM_ADDR_W-1:0] shift_i,
  input  logic signed [MEM_ADDR_W-1:0] shift2_i,
  output logic        [MEM_ADDR_W-1:0] addr_o,
  output logic                         mem_en_o,
  output logic                         last_o,
  output logic                         done_o
);

  localparam logic [PERIOD_W-1:0] ONE_P = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0]   ONE_I = {{(ITER_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DLY, RUN} state_t;

  // A zero period length means a one-cycle period.
  function automatic logic [PERIOD_W-1:0] min1_p(input logic [PERIOD_W-1:0] v);
    return (v == '0) ? ONE_P : v;
  endfunction

  // A zero iteration count means a single iteration.
  function automatic logic [ITER_W-1:0] min1_i(input logic [ITER_W-1:0] v);
    return (v == '0) ? ONE_I : v;
  endfunction

  // Duty can never exceed the (effective) period.
  function automatic logic [PERIOD_W-1:0] clamp_duty(input logic [PERIOD_W-1:0] d,
                                                     input logic [PERIOD_W-1:0] p);
    return (d > p) ? p : d;
  endfunction

  state_t state, state_nxt;

  logic        [MEM_ADDR_W-1:0] addr_q, addr_nxt;
  logic                         mem_en_q, mem_en_nxt;
  logic                         last_q, last_nxt;
  logic                         done_q, done_nxt;
  logic        [PERIOD_W-1:0]   per_cnt, per_nxt;
  logic        [PERIOD_W-1:0]   dly_cnt, dly_nxt;
  logic        [ITER_W-1:0]     iter_cnt, iter_nxt;
  logic        [ITER_W-1:0]     iter2_cnt, iter2_nxt;

  logic        [PERIOD_W-1:0]   eff_period, eff_duty;
  logic        [ITER_W-1:0]     eff_iter, eff_iter2;
  logic                         period_end, block_end, run_end;
  logic                         first_en, first_last;
  logic signed [MEM_ADDR_W-1:0] step;

  assign eff_period = min1_p(period_i);
  assign eff_duty   = clamp_duty(duty_i, eff_period);
  assign eff_iter   = min1_i(iterations_i);
  assign eff_iter2  = min1_i(iterations2_i);

  assign period_end = (per_cnt == eff_period);
  assign block_end  = period_end && (iter_cnt == eff_iter);
  assign run_end    = block_end && (iter2_cnt == eff_iter2);

  // Outputs for the first RUN cycle, where all counters equal 1.
  assign first_en   = (eff_duty != '0);
  assign first_last = (eff_period == ONE_P) && (eff_iter == ONE_I) && (eff_iter2 == ONE_I);

  // Address step for the current cycle; two's-complement wrap is intended.
  assign step = (mem_en_q   ? incr_i   : '0)
              + (period_end ? shift_i  : '0)
              + (block_end  ? shift2_i : '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, counter and output computation; ready_i low holds everything.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    mem_en_nxt = mem_en_q;
    last_nxt   = last_q;
    done_nxt   = done_q;
    per_nxt    = per_cnt;
    dly_nxt    = dly_cnt;
    iter_nxt   = iter_cnt;
    iter2_nxt  = iter2_cnt;
    unique case (state)
      IDLE: begin
        if (run_i && ready_i) begin
          addr_nxt  = start_i;
          per_nxt   = ONE_P;
          iter_nxt  = ONE_I;
          iter2_nxt = ONE_I;
          done_nxt  = 1'b0;
          if (delay_i == '0) begin
            state_nxt  = RUN;
            mem_en_nxt = first_en;
            last_nxt   = first_last;
          end else begin
            state_nxt = DLY;
            dly_nxt   = delay_i;
          end
        end else if (init_i) begin
          addr_nxt  = start_i;
          per_nxt   = ONE_P;
          dly_nxt   = ONE_P;
          iter_nxt  = ONE_I;
          iter2_nxt = ONE_I;
        end
      end
      DLY: begin
        if (ready_i) begin
          if (dly_cnt <= ONE_P) begin
            state_nxt  = RUN;
            per_nxt    = ONE_P;
            mem_en_nxt = first_en;
            last_nxt   = first_last;
          end else begin
            dly_nxt = dly_cnt - ONE_P;
          end
        end
      end
      RUN: begin
        if (ready_i) begin
          addr_nxt = addr_q + step;
          if (run_end) begin
            if (run_i) begin
              // Seamless chained run: no delay, done_o stays low.
              addr_nxt   = start_i;
              per_nxt    = ONE_P;
              iter_nxt   = ONE_I;
              iter2_nxt  = ONE_I;
              mem_en_nxt = first_en;
              last_nxt   = first_last;
            end else begin
              state_nxt  = IDLE;
              done_nxt   = 1'b1;
              mem_en_nxt = 1'b0;
              last_nxt   = 1'b0;
            end
          end else begin
            per_nxt    = period_end ? ONE_P : per_cnt + ONE_P;
            iter_nxt   = block_end ? ONE_I : (period_end ? iter_cnt + ONE_I : iter_cnt);
            iter2_nxt  = block_end ? iter2_cnt + ONE_I : iter2_cnt;
            mem_en_nxt = (per_nxt <= eff_duty);
            last_nxt   = (per_nxt == eff_period) && (iter_nxt == eff_iter) &&
                         (iter2_nxt == eff_iter2);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q    <= '0;
      mem_en_q  <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b1;
      per_cnt   <= '0;
      dly_cnt   <= '0;
      iter_cnt  <= '0;
      iter2_cnt <= '0;
    end else begin
      addr_q    <= addr_nxt;
      mem_en_q  <= mem_en_nxt;
      last_q    <= last_nxt;
      done_q    <= done_nxt;
      per_cnt   <= per_nxt;
      dly_cnt   <= dly_nxt;
      iter_cnt  <= iter_nxt;
      iter2_cnt <= iter2_nxt;
    end
  end

  assign addr_o   = addr_q;
  assign mem_en_o = mem_en_q;
  assign last_o   = last_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_xaddrgen_2d.sv
// Bench for xaddrgen_2d: table of configurations with hand-derived address
// sequences, per-cycle expectations queued at run start and checked each cycle.
module tb_xaddrgen_2d;

  logic       clk = 1'b0;
  logic       rst_n, init, run, ready;
  logic [9:0] iterations, iterations2, period, duty, delay;
  logic [9:0] start, incr, shift, shift2;
  logic [9:0] addr;
  logic       mem_en, last, done;

  xaddrgen_2d dut (
    .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .run_i(run), .ready_i(ready),
    .iterations_i(iterations), .iterations2_i(iterations2),
    .period_i(period), .duty_i(duty), .delay_i(delay),
    .start_i(start), .incr_i(incr), .shift_i(shift), .shift2_i(shift2),
    .addr_o(addr), .mem_en_o(mem_en), .last_o(last), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start, incr, shift, shift2;
    int         period, duty, delay, iter, iter2;
    int         n;
    logic [7:0] en;
  } vec_t;

  typedef struct {
    int         cyc;
    int         id;
    logic       en;
    logic [9:0] addr;
    logic       last;
    logic       done;
  } exp_t;

  localparam int NV = 9;
  vec_t tbl [NV];
  int exp_addr [NV][8] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7},
    '{0, 1, 2, 2, 12, 13, 14, 14},
    '{0, 1, 2, 3, 104, 105, 106, 107},
    '{0, 1, 2, 3, 104, 105, 106, 107},
    '{1020, 1023, 2, 0, 0, 0, 0, 0},
    '{5, 4, 3, 1016, 1015, 1014, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{7, 9, 11, 0, 0, 0, 0, 0},
    '{33, 0, 0, 0, 0, 0, 0, 0}
  };

  exp_t sb [$];
  int nvec = 0;
  int nerr = 0;

  // Scoreboard consumer: compare the entry due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      nvec++; nerr++;
      $display("FAIL vec%0d missed check at cycle %0d (now %0d)", sb[0].id, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      if (mem_en !== e.en || last !== e.last || done !== e.done ||
          (e.en && addr !== e.addr)) begin
        nerr++;
        $display("FAIL vec%0d cyc%0d: got en=%b addr=%0d last=%b done=%b, want en=%b addr=%0d last=%b done=%b",
                 e.id, cyc, mem_en, addr, last, done, e.en, e.addr, e.last, e.done);
      end
    end
  end

  task automatic setv(input int i, input int st, input int inc, input int sh, input int sh2,
                      input int per, input int du, input int dl, input int it, input int it2,
                      input int n, input logic [7:0] en);
    tbl[i].start = st;   tbl[i].incr = inc;  tbl[i].shift = sh;  tbl[i].shift2 = sh2;
    tbl[i].period = per; tbl[i].duty = du;   tbl[i].delay = dl;
    tbl[i].iter = it;    tbl[i].iter2 = it2; tbl[i].n = n;       tbl[i].en = en;
  endtask

  task automatic apply_cfg(input int v);
    start  = 10'(tbl[v].start);  incr   = 10'(tbl[v].incr);
    shift  = 10'(tbl[v].shift);  shift2 = 10'(tbl[v].shift2);
    period = 10'(tbl[v].period); duty   = 10'(tbl[v].duty);
    delay  = 10'(tbl[v].delay);
    iterations = 10'(tbl[v].iter); iterations2 = 10'(tbl[v].iter2);
  endtask

  task automatic push(input int c, input int id, input logic en, input int a,
                      input logic lst, input logic dn);
    exp_t e;
    e.cyc = c; e.id = id; e.en = en; e.addr = 10'(a); e.last = lst; e.done = dn;
    sb.push_back(e);
  endtask

  // Start run v in the current cycle; optionally stall before index stall_at
  // for stall_len cycles, and chain reps runs back-to-back.
  task automatic do_run(input int v, input int stall_at, input int stall_len, input int reps);
    int t, c, k, extra, end_c, s_cyc;
    int lastc [8];
    apply_cfg(v);
    t = cyc;
    c = t + 1;
    extra = (stall_at >= 0) ? stall_len : 0;
    for (int d = 0; d < tbl[v].delay; d++) begin
      push(c, v, 1'b0, 0, 1'b0, 1'b0); c++;
    end
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        k = (r == 0 && i == stall_at) ? stall_len + 1 : 1;
        for (int j = 0; j < k; j++) begin
          push(c, v, tbl[v].en[i], exp_addr[v][i], i == tbl[v].n - 1, 1'b0); c++;
        end
      end
      lastc[r] = t + tbl[v].delay + extra + (r + 1) * tbl[v].n;
    end
    push(c, v, 1'b0, 0, 1'b0, 1'b1);
    end_c = c;
    s_cyc = t + tbl[v].delay + 1 + stall_at;
    run = 1'b1;
    while (cyc <= end_c) begin
      @(posedge clk); #1;
      run = 1'b0;
      for (int r = 0; r < reps - 1; r++)
        if (cyc == lastc[r]) run = 1'b1;
      if (stall_at >= 0 && cyc == s_cyc) ready = 1'b0;
      if (stall_at >= 0 && cyc == s_cyc + stall_len) ready = 1'b1;
    end
    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL vec%0d drain: %0d entries left, want 0", v, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset(input int id);
    nvec++;
    if (addr !== 10'd0 || mem_en !== 1'b0 || last !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL reset%0d: got addr=%0d en=%b last=%b done=%b, want 0/0/0/1",
               id, addr, mem_en, last, done);
    end
  endtask

  initial begin
    setv(0,    0,  1,   0,   0, 4, 4, 0, 2, 1, 8, 8'hFF);
    setv(1,    0,  1,  10,   0, 4, 2, 0, 2, 1, 8, 8'h33);
    setv(2,    0,  1,   0, 100, 2, 2, 0, 2, 2, 8, 8'hFF);
    setv(3,    0,  1,   0, 100, 2, 2, 3, 2, 2, 8, 8'hFF);
    setv(4, 1020,  3,   0,   0, 3, 3, 0, 1, 1, 3, 8'h07);
    setv(5,    5, -1, -10,   0, 3, 3, 0, 2, 1, 6, 8'h3F);
    setv(6,    0,  1,   0,   0, 2, 0, 0, 2, 1, 4, 8'h00);
    setv(7,    7,  2,   0,   0, 3, 7, 0, 1, 1, 3, 8'h07);
    setv(8,   33,  5,   0,   0, 0, 1, 0, 0, 0, 1, 8'h01);

    rst_n = 1'b0; init = 1'b0; run = 1'b0; ready = 1'b1;
    apply_cfg(0);
    #12;
    check_reset(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) do_run(v, -1, 0, 1);

    // Stall three cycles while address 2 is presented.
    do_run(0, 2, 3, 1);
    // Back-to-back chains, including the wrapping sequence and a one-cycle run.
    do_run(0, -1, 0, 2);
    do_run(4, -1, 0, 2);
    do_run(8, -1, 0, 3);

    // Asynchronous reset between clock edges in the middle of a run.
    apply_cfg(0);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset(2);

    // init loads the start address without leaving idle, then a replay.
    apply_cfg(4);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    nvec++;
    if (addr !== 10'd1020 || mem_en !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL init: got addr=%0d en=%b done=%b, want 1020/0/1", addr, mem_en, done);
    end
    do_run(4, -1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/xaddrgen_2d.md
Name: xaddrgen_2d

Overview:
- Two-level nested-loop address generator for Versat memory-backed functional units; successor to the single-level duty/period generator.
- Inner loop: a period of PERIOD_W-counted cycles, with the first duty_i cycles enabled. Middle loop: iterations_i periods. Outer loop: iterations2_i middle blocks, with a per-level address shift.
- Adds ready_i backpressure in place of pause, a last_o marker and configurable degenerate-case handling. Drives one memory port's address and enable.

Parameters:
- MEM_ADDR_W, 10, address width; all address arithmetic is modulo 2^MEM_ADDR_W.
- PERIOD_W, 10, width of period_i, duty_i and delay_i.
- ITER_W, 10, width of iterations_i and iterations2_i.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- init_i  in  1  load start address and clear counters (IDLE only).
- run_i  in  1  start a run, or chain a back-to-back run on the final cycle.
- ready_i  in  1  consumer ready; 0 freezes all state and outputs.
- iterations_i  in  ITER_W  periods per middle block (0 treated as 1).
- iterations2_i  in  ITER_W  middle blocks per run (0 treated as 1).
- period_i  in  PERIOD_W  cycles per period (0 treated as 1).
- duty_i  in  PERIOD_W  enabled cycles per period; values > period_i clamp to period_i.
- delay_i  in  PERIOD_W  idle cycles between run acceptance and the first period.
- start_i  in  MEM_ADDR_W  start address.
- incr_i  in  MEM_ADDR_W signed  added after each enabled cycle.
- shift_i  in  MEM_ADDR_W signed  added at the end of every period.
- shift2_i  in  MEM_ADDR_W signed  added additionally at the end of every middle block.
- addr_o  out  MEM_ADDR_W  registered address.
- mem_en_o  out  1  registered enable; addr_o is valid when mem_en_o = 1.
- last_o  out  1  high with the final cycle of the run.
- done_o  out  1  high when idle.

Behaviour:
- Reset (async, rst_n_i = 0):
  - state = IDLE; addr_o = 0; mem_en_o = 0; last_o = 0; done_o = 1.
  - All counters = 0.
  - Reset mid-run aborts immediately; no completion is signalled.
- States: IDLE, DELAY, RUN. Configuration is sampled every cycle and must be held stable during a run.
- IDLE:
  - done_o = 1, mem_en_o = 0.
  - init_i: addr register <= start_i, counters <= 1.
  - run_i:
    - done_o <= 0 and addr <= start_i (also without init_i).
    - If delay_i = 0, go to RUN with per_cnt = 1.
    - Otherwise go to DELAY with dly_cnt = delay_i.
  - init_i and run_i together act as run_i.
- DELAY: dly_cnt decrements every cycle; on reaching 1, go to RUN with per_cnt = 1.
- Latency: run_i in cycle T gives the first possible mem_en_o = 1 in cycle T+1+delay_i.
- RUN, per advancing cycle (ready_i = 1):
  - mem_en_o = (per_cnt <= eff_duty).
  - Next address = addr + (mem_en_o ? incr_i : 0) + (period end ? shift_i : 0) + (block end ? shift2_i : 0).
    - Period end: per_cnt = eff_period.
    - Block end: period end and iter = eff_iter.
  - At period end: per_cnt <= 1 and iter <= iter+1.
  - At block end: iter <= 1 and iter2 <= iter2+1.
- Run end: the period end with iter = eff_iter and iter2 = eff_iter2.
  - last_o = 1 in that cycle.
  - If run_i = 1 in that cycle: restart seamlessly. addr <= start_i, all counters <= 1, state stays RUN, done_o stays 0, and delay is not reapplied.
  - Otherwise: go to IDLE and done_o <= 1 on the next cycle.
- duty_i = 0: no enables are produced, but counters, shifts, last_o and done_o behave normally.
- ready_i = 0: every register holds, including addr_o, mem_en_o and last_o. An address presented with ready_i low is consumed only on the cycle ready_i = 1. ready_i has no effect in IDLE except freezing the run_i transition.
- Wrap-around: addr overflow or underflow wraps modulo 2^MEM_ADDR_W without error.

Test Plan:
- start=0, incr=1, shift=0, period=duty=4, iter=2, iter2=1, delay=0; run at T -> mem_en_o=1 at T+1..T+8 with addr_o 0..7, last_o at T+8, done_o=1 from T+9.
- Same, but duty=2, shift=10 -> enabled addresses 0,1 at T+1,T+2 and 12,13 at T+5,T+6. mem_en_o=0 at T+3,T+4,T+7,T+8; last_o at T+8.
- period=duty=2, incr=1, iter=2, iter2=2, shift2=100 -> addresses 0,1,2,3,104,105,106,107 on consecutive cycles; delay=3 shifts the first enable to T+4.
- Stall: ready_i=0 for 3 cycles after addr_o=2 in test 1 -> addr_o and mem_en_o held at 2/1; sequence resumes with 3 and the total length extends by 3.
- Back-to-back: run_i held high in the last_o cycle -> addr_o restarts at start_i the next cycle, done_o never rises. Also: start=1020, incr=3 with MEM_ADDR_W=10 -> addresses 1020, 1023, 2 (wrap).
- rst_n_i pulsed low mid-run (asynchronous, between clock edges) -> outputs immediately 0/0/0/done=1; a subsequent init_i and run_i replay the sequence from start_i.
